rom_mc: RTL and testbench

- Parametrised multi-channel synchronous ROM.
- Several requesters share one block-RAM array of configurable width and depth through a round-robin arbiter with a req/ack handshake.
- Optional output pipeline register.
- Runtime load port lets the HPS/ioctl download path overwrite contents, e.g. a cartridge GROM or system ROM.
- Replaces per-consumer single-port ROM instances where several engines (CPU, GROM, VDP helper) read the same image.

---
 rtl/rom_mc.sv | 137 +++++++++++++
 tb/tb_rom_mc.sv | 263 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/rom_mc.sv
// rom_mc: multi-channel synchronous-read ROM image shared by several requesters.
// Round-robin arbitration with a req/ack handshake, optional output register,
// and a load port that rewrites the image at runtime.
module rom_mc #(
  parameter              init_file = "",
  parameter int unsigned awidth    = 12,
  parameter int unsigned dwidth    = 8,
  parameter int unsigned channels  = 2,
  parameter int unsigned outreg    = 0
) (
  input  logic                       clock,
  input  logic                       reset_n,
  input  logic [channels-1:0]        ch_req,
  input  logic [channels*awidth-1:0] ch_addr,
  output logic [channels-1:0]        ch_ack,
  output logic [channels*dwidth-1:0] ch_data,
  input  logic                       ld_we,
  input  logic [awidth-1:0]          ld_addr,
  input  logic [dwidth-1:0]          ld_data,
  output logic                       busy
);

  localparam int unsigned depth = 1 << awidth;
  localparam int unsigned chw   = (channels > 1) ? $clog2(channels) : 1;

  // Image storage; the synthesis flow may preload it from init_file
  (* ram_init_file = init_file *)
  logic [dwidth-1:0] mem [depth];
  logic [dwidth-1:0] mem_rd_q;

  logic [channels-1:0]        inflight_q, inflight_d;
  logic [channels-1:0]        ack_q, ack_d;
  logic [channels*dwidth-1:0] data_q, data_d;
  logic [chw-1:0]             ptr_q, ptr_d;
  logic                       busy_q, busy_d;

  // Stage 1 tracks the read issued into the array; stage 2 is the optional output register
  logic                       s1_vld_q, s1_vld_d;
  logic [chw-1:0]             s1_ch_q, s1_ch_d;
  logic                       s2_vld_q, s2_vld_d;
  logic [chw-1:0]             s2_ch_q, s2_ch_d;
  logic [dwidth-1:0]          s2_data_q, s2_data_d;

  logic [channels-1:0]        elig_c;
  logic [chw-1:0]             cand_c;
  logic                       gnt_vld_c;
  logic [chw-1:0]             gnt_ch_c;
  logic [awidth-1:0]          rd_addr_c;
  logic                       fin_vld_c;
  logic [chw-1:0]             fin_ch_c;
  logic [dwidth-1:0]          fin_data_c;

  // Round-robin grant search from the pointer; the load port blocks grants
  always_comb begin
    elig_c    = ch_req & ~inflight_q & ~ack_q;
    gnt_vld_c = 1'b0;
    gnt_ch_c  = '0;
    cand_c    = '0;
    for (int unsigned i = 0; i < channels; i++) begin
      cand_c = chw'((32'(ptr_q) + i) % channels);
      if (!gnt_vld_c && !ld_we && elig_c[cand_c]) begin
        gnt_vld_c = 1'b1;
        gnt_ch_c  = cand_c;
      end
    end
    rd_addr_c = ch_addr[gnt_ch_c*awidth +: awidth];
  end

  // Completion bookkeeping: acks, per-channel data hold, in-flight flags, pointer
  always_comb begin
    fin_vld_c  = (outreg != 0) ? s2_vld_q  : s1_vld_q;
    fin_ch_c   = (outreg != 0) ? s2_ch_q   : s1_ch_q;
    fin_data_c = (outreg != 0) ? s2_data_q : mem_rd_q;

    s1_vld_d   = gnt_vld_c;
    s1_ch_d    = gnt_ch_c;
    s2_vld_d   = s1_vld_q;
    s2_ch_d    = s1_ch_q;
    s2_data_d  = mem_rd_q;

    ack_d      = '0;
    data_d     = data_q;
    inflight_d = inflight_q;
    ptr_d      = ptr_q;

    if (fin_vld_c) begin
      ack_d[fin_ch_c]                     = 1'b1;
      data_d[fin_ch_c*dwidth +: dwidth]   = fin_data_c;
      inflight_d[fin_ch_c]                = 1'b0;
    end
    if (gnt_vld_c) begin
      inflight_d[gnt_ch_c] = 1'b1;
      ptr_d = (32'(gnt_ch_c) == channels - 1) ? '0 : gnt_ch_c + chw'(1);
    end
    busy_d = |inflight_d;
  end

  // Control and output registers; a reset discards every in-flight read
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      inflight_q <= '0;
      ack_q      <= '0;
      data_q     <= '0;
      ptr_q      <= '0;
      busy_q     <= 1'b0;
      s1_vld_q   <= 1'b0;
      s1_ch_q    <= '0;
      s2_vld_q   <= 1'b0;
      s2_ch_q    <= '0;
      s2_data_q  <= '0;
    end else begin
      inflight_q <= inflight_d;
      ack_q      <= ack_d;
      data_q     <= data_d;
      ptr_q      <= ptr_d;
      busy_q     <= busy_d;
      s1_vld_q   <= s1_vld_d;
      s1_ch_q    <= s1_ch_d;
      s2_vld_q   <= s2_vld_d;
      s2_ch_q    <= s2_ch_d;
      s2_data_q  <= s2_data_d;
    end
  end

  // Synchronous-read array with load-port write; a same-edge read sees old contents
  always_ff @(posedge clock) begin
    if (ld_we) begin
      mem[ld_addr] <= ld_data;
    end
    mem_rd_q <= mem[rd_addr_c];
  end

  assign ch_ack  = ack_q;
  assign ch_data = data_q;
  assign busy    = busy_q;

endmodule

// File: tb/tb_rom_mc.sv
// tb_rom_mc: scoreboard bench for rom_mc, run against an outreg=0 and an outreg=1 instance.
module tb_rom_mc;

  typedef struct {
    int         ch;
    logic [7:0] data;
    int         at;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  int          cyc = 0;
  int          n_cmp = 0;
  int          n_bad = 0;

  logic [1:0]  req     [2];
  logic [23:0] addr    [2];
  logic [1:0]  ack     [2];
  logic [15:0] dat     [2];
  logic        busy    [2];
  logic        ld_we   [2];
  logic [11:0] ld_addr [2];
  logic [7:0]  ld_data [2];

  exp_t q0[$];
  exp_t q1[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  rom_mc #(.init_file(""), .awidth(12), .dwidth(8), .channels(2), .outreg(0)) u_dut0 (
    .clock(clk), .reset_n(rst_n), .ch_req(req[0]), .ch_addr(addr[0]), .ch_ack(ack[0]),
    .ch_data(dat[0]), .ld_we(ld_we[0]), .ld_addr(ld_addr[0]), .ld_data(ld_data[0]), .busy(busy[0])
  );

  rom_mc #(.init_file(""), .awidth(12), .dwidth(8), .channels(2), .outreg(1)) u_dut1 (
    .clock(clk), .reset_n(rst_n), .ch_req(req[1]), .ch_addr(addr[1]), .ch_ack(ack[1]),
    .ch_data(dat[1]), .ld_we(ld_we[1]), .ld_addr(ld_addr[1]), .ld_data(ld_data[1]), .busy(busy[1])
  );

  function automatic logic [7:0] img(input logic [11:0] a);
    return a[7:0] ^ 8'h5A;
  endfunction

  task automatic chk(input string name, input int d, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s dut%0d: got %h, expected %h (cycle %0d)", name, d, got, exp, cyc);
    end
  endtask

  task automatic push(input int d, input int c, input logic [7:0] v, input int at);
    exp_t e;
    e.ch = c;
    e.data = v;
    e.at = at;
    if (d == 0) q0.push_back(e);
    else q1.push_back(e);
  endtask

  // Monitor: every ack is popped against the scoreboard
  task automatic check_ack(input int d, input int c);
    exp_t e;
    logic [7:0] got;
    got = dat[d][c*8 +: 8];
    if ((d == 0 && q0.size() == 0) || (d == 1 && q1.size() == 0)) begin
      n_cmp++;
      n_bad++;
      $display("FAIL unexpected_ack dut%0d: ch%0d data %h at cycle %0d, expected no ack", d, c, got, cyc);
      return;
    end
    if (d == 0) e = q0.pop_front();
    else e = q1.pop_front();
    chk("ack_channel", d, 32'(c), 32'(e.ch));
    chk("ack_data", d, 32'(got), 32'(e.data));
    chk("ack_cycle", d, 32'(cyc), 32'(e.at));
  endtask

  always @(negedge clk) begin
    for (int d = 0; d < 2; d++)
      for (int c = 0; c < 2; c++)
        if (ack[d][c] === 1'b1) check_ack(d, c);
  end

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  // Hold requests until acked (inspects the current negedge first), bounded
  task automatic serve(input int d, input int bound);
    int n;
    n = 0;
    while (1) begin
      for (int c = 0; c < 2; c++)
        if (ack[d][c] === 1'b1) req[d][c] = 1'b0;
      if (req[d] == 2'b00 || n >= bound) break;
      @(negedge clk);
      n++;
    end
    if (req[d] != 2'b00) begin
      chk("serve_timeout", d, 32'(req[d]), 32'd0);
      req[d] = 2'b00;
    end
  endtask

  task automatic run_all(input int d);
    int o;
    int k;
    int n;
    int cnt;
    o = d;

    // Reset state
    do_reset();
    chk("reset_ack", d, 32'(ack[d]), 32'd0);
    chk("reset_data", d, 32'(dat[d]), 32'd0);
    chk("reset_busy", d, 32'(busy[d]), 32'd0);

    // Single read of 0x003
    @(negedge clk);
    k = cyc;
    addr[d][11:0] = 12'h003;
    req[d] = 2'b01;
    push(d, 0, 8'h59, k + 2 + o);
    serve(d, 20);
    repeat (2) @(negedge clk);

    // Simultaneous requests with the pointer at 0
    do_reset();
    @(negedge clk);
    k = cyc;
    addr[d] = {12'h020, 12'h010};
    req[d] = 2'b11;
    push(d, 0, 8'h4A, k + 2 + o);
    push(d, 1, 8'h7A, k + 3 + o);
    serve(d, 20);
    repeat (2) @(negedge clk);

    // Both requests held continuously: alternating grants with the one-cycle gap
    do_reset();
    @(negedge clk);
    k = cyc;
    addr[d] = {12'h1FF, 12'h100};
    req[d] = 2'b11;
    for (int j = 0; j < 2; j++)
      for (int c = 0; c < 2; c++)
        push(d, c, (c == 0) ? 8'h5A : 8'hA5, k + 2 + o + c + j * (3 + o));
    n = 0;
    cnt = 0;
    while (cnt < 4 && n < 40) begin
      @(negedge clk);
      n++;
      cnt += int'(ack[d][0]) + int'(ack[d][1]);
    end
    req[d] = 2'b00;
    chk("continuous_ack_count", d, 32'(cnt), 32'd4);
    repeat (4) @(negedge clk);

    // Load-port write blocks the grant; the later read sees the new value
    @(negedge clk);
    k = cyc;
    addr[d][11:0] = 12'h003;
    req[d] = 2'b01;
    ld_we[d] = 1'b1;
    ld_addr[d] = 12'h003;
    ld_data[d] = 8'hC3;
    push(d, 0, 8'hC3, k + 3 + o);
    @(negedge clk);
    ld_we[d] = 1'b0;
    chk("no_grant_on_write", d, 32'(busy[d]), 32'd0);
    serve(d, 20);
    chk("ch1_data_held", d, 32'(dat[d][15:8]), 32'h0000_00A5);
    repeat (2) @(negedge clk);

    // Read issued the cycle before a write to the same address returns old data
    @(negedge clk);
    k = cyc;
    addr[d][11:0] = 12'h004;
    req[d] = 2'b01;
    push(d, 0, 8'h5E, k + 2 + o);
    @(negedge clk);
    ld_we[d] = 1'b1;
    ld_addr[d] = 12'h004;
    ld_data[d] = 8'h11;
    @(negedge clk);
    ld_we[d] = 1'b0;
    serve(d, 20);
    @(negedge clk);
    k = cyc;
    req[d] = 2'b01;
    push(d, 0, 8'h11, k + 2 + o);
    serve(d, 20);
    repeat (2) @(negedge clk);

    // Reset one cycle after a grant discards the read
    @(negedge clk);
    addr[d][11:0] = 12'h010;
    req[d] = 2'b01;
    @(negedge clk);
    chk("busy_after_grant", d, 32'(busy[d]), 32'd1);
    rst_n = 1'b0;
    #1;
    chk("midreset_ack", d, 32'(ack[d]), 32'd0);
    chk("midreset_data", d, 32'(dat[d]), 32'd0);
    chk("midreset_busy", d, 32'(busy[d]), 32'd0);
    req[d] = 2'b00;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (4) @(negedge clk);
    chk("post_reset_busy", d, 32'(busy[d]), 32'd0);
    chk("post_reset_data", d, 32'(dat[d]), 32'd0);
    @(negedge clk);
    k = cyc;
    addr[d] = {12'h020, 12'h010};
    req[d] = 2'b11;
    push(d, 0, 8'h4A, k + 2 + o);
    push(d, 1, 8'h7A, k + 3 + o);
    serve(d, 20);
    repeat (4) @(negedge clk);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
    $fatal(1);
  end

  initial begin
    for (int d = 0; d < 2; d++) begin
      req[d] = 2'b00;
      addr[d] = '0;
      ld_we[d] = 1'b0;
      ld_addr[d] = '0;
      ld_data[d] = '0;
    end

    // Download the test image through the load port
    for (int a = 0; a < 4096; a++) begin
      @(negedge clk);
      for (int d = 0; d < 2; d++) begin
        ld_we[d] = 1'b1;
        ld_addr[d] = 12'(a);
        ld_data[d] = img(12'(a));
      end
    end
    @(negedge clk);
    for (int d = 0; d < 2; d++) ld_we[d] = 1'b0;

    run_all(0);
    run_all(1);

    repeat (4) @(negedge clk);
    chk("scoreboard_empty", 0, 32'(q0.size()), 32'd0);
    chk("scoreboard_empty", 1, 32'(q1.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
